// File: rtl/approx_metric_pkg.sv
// Shared definitions for approximate-arithmetic metric blocks.
// Holds the monitor state encoding and the default operand, counter and
// accumulator widths so every metric block and its bench agree on them.
package approx_metric_pkg;

   localparam int unsigned DEF_W     = 32;
   localparam int unsigned DEF_CNT_W = 32;
   localparam int unsigned DEF_SUM_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCUM  = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_DIVIDE = 3'd3,
      ST_DONE   = 3'd4
   } metric_state_e;

endpackage

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request; operands sampled in this cycle (ignored while busy)
//   dividend, divisor   SUM_W-bit unsigned operands (divisor must be non-zero)
//   busy                a division is in flight after the start cycle
//   done                high in the cycle the last quotient bit is produced
//   quotient            floor(dividend / divisor), valid while done is high
// The first quotient bit is formed in the start cycle itself, straight from the
// operand inputs, so a full division occupies exactly SUM_W cycles counting the
// start cycle. quotient is the combinational next value of the shift register,
// which is why the caller must capture it while done is high.
module seq_divider #(
   parameter int unsigned SUM_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SUM_W-1:0] dividend,
   input  logic [SUM_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] quotient
);

   localparam int unsigned CW = $clog2(SUM_W + 1);

   logic [SUM_W-1:0] rem_q, rem_d;
   logic [SUM_W-1:0] dq_q, dq_d;     // dividend bits shift out, quotient bits shift in
   logic [SUM_W-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;

   logic [SUM_W-1:0] rem_src, dq_src, dvs_src;
   logic [SUM_W:0]   trial;
   logic             qbit, step;
   logic [CW-1:0]    step_cnt;

   always_comb begin
      rem_src  = rem_q;
      dq_src   = dq_q;
      dvs_src  = dvs_q;
      step     = busy_q;
      step_cnt = cnt_q;
      if (start && !busy_q) begin
         rem_src  = '0;
         dq_src   = dividend;
         dvs_src  = divisor;
         step     = 1'b1;
         step_cnt = '0;
      end
      trial  = {rem_src, dq_src[SUM_W-1]};
      qbit   = (trial >= {1'b0, dvs_src});
      rem_d  = rem_q;
      dq_d   = dq_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done   = 1'b0;
      if (step) begin
         rem_d = qbit ? SUM_W'(trial - {1'b0, dvs_src}) : trial[SUM_W-1:0];
         dq_d  = {dq_src[SUM_W-2:0], qbit};
         dvs_d = dvs_src;
         if (step_cnt == CW'(SUM_W - 1)) begin
            done   = 1'b1;
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            busy_d = 1'b1;
            cnt_d  = step_cnt + CW'(1);
         end
      end
      quotient = dq_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         dq_q   <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dq_q   <= dq_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/err_metric_monitor.sv
// Error-metric monitor for an approximate arithmetic unit.
// Over a window of n_samples accepted (exact, approx) pairs it counts
// mismatches, tracks the largest and the saturating sum of |exact - approx|,
// then divides the sum by the window length to give the mean error distance.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, n_samples         open a window (accepted in IDLE/DONE only)
//   in_valid/in_ready        pair handshake: a pair transfers on a rising edge
//                            where in_valid && in_ready; in_ready never depends
//                            on in_valid, and in_valid has no effect otherwise
//   exact, approx            W-bit reference and approximate results
//   busy, done               window in progress / results valid and held
//   err_cnt, max_ed, sum_ed, sum_sat, mean_ed   window results
//   dbg_state                current FSM state
module err_metric_monitor
   import approx_metric_pkg::*;
#(
   parameter int unsigned W     = DEF_W,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned SUM_W = DEF_SUM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     exact,
   input  logic [W-1:0]     approx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_cnt,
   output logic [W-1:0]     max_ed,
   output logic [SUM_W-1:0] sum_ed,
   output logic             sum_sat,
   output logic [SUM_W-1:0] mean_ed,
   output metric_state_e    dbg_state
);

   metric_state_e    state_q, state_d;
   logic [CNT_W-1:0] n_lat_q, n_lat_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             s1_valid_q, s1_valid_d;
   logic [W-1:0]     s1_diff_q, s1_diff_d;
   logic             s1_mis_q, s1_mis_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [W-1:0]     max_q, max_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             sat_q, sat_d;
   logic [SUM_W-1:0] mean_q, mean_d;

   logic             xfer;
   logic [SUM_W:0]   sum_ext;
   logic             div_start, div_busy, div_done;
   logic [SUM_W-1:0] div_quo;

   assign in_ready = (state_q == ST_ACCUM) && (acc_cnt_q < n_lat_q);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      n_lat_d    = n_lat_q;
      acc_cnt_d  = acc_cnt_q;
      s1_valid_d = xfer;
      s1_diff_d  = s1_diff_q;
      s1_mis_d   = s1_mis_q;
      err_cnt_d  = err_cnt_q;
      max_d      = max_q;
      sum_d      = sum_q;
      sat_d      = sat_q;
      mean_d     = mean_q;
      div_start  = 1'b0;

      // Stage 1: absolute difference without wrap, taken in W bits.
      if (xfer) begin
         s1_diff_d = (exact >= approx) ? (exact - approx) : (approx - exact);
         s1_mis_d  = (exact != approx);
      end

      // Stage 2: one extra bit on the sum exposes overflow for the clamp.
      sum_ext = {1'b0, sum_q} + (SUM_W+1)'(s1_diff_q);
      if (s1_valid_q) begin
         err_cnt_d = err_cnt_q + CNT_W'(s1_mis_q);
         if (s1_diff_q > max_q) max_d = s1_diff_q;
         if (sum_ext[SUM_W]) begin
            sum_d = '1;
            sat_d = 1'b1;
         end else begin
            sum_d = sum_ext[SUM_W-1:0];
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               n_lat_d   = n_samples;
               acc_cnt_d = '0;
               err_cnt_d = '0;
               max_d     = '0;
               sum_d     = '0;
               sat_d     = 1'b0;
               mean_d    = '0;
               state_d   = (n_samples == '0) ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (xfer) begin
               acc_cnt_d = acc_cnt_q + CNT_W'(1);
               if (acc_cnt_q + CNT_W'(1) == n_lat_q) state_d = ST_DRAIN;
            end
         end
         // Stage 2 absorbs the final pair on this cycle's edge.
         ST_DRAIN: state_d = ST_DIVIDE;
         // sum_q is final on the first DIVIDE cycle; the divider reads it then.
         ST_DIVIDE: begin
            div_start = !div_busy;
            if (div_done) begin
               mean_d  = div_quo;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         n_lat_q    <= '0;
         acc_cnt_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_diff_q  <= '0;
         s1_mis_q   <= 1'b0;
         err_cnt_q  <= '0;
         max_q      <= '0;
         sum_q      <= '0;
         sat_q      <= 1'b0;
         mean_q     <= '0;
      end else begin
         state_q    <= state_d;
         n_lat_q    <= n_lat_d;
         acc_cnt_q  <= acc_cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_diff_q  <= s1_diff_d;
         s1_mis_q   <= s1_mis_d;
         err_cnt_q  <= err_cnt_d;
         max_q      <= max_d;
         sum_q      <= sum_d;
         sat_q      <= sat_d;
         mean_q     <= mean_d;
      end
   end

   seq_divider #(.SUM_W(SUM_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (sum_q),
      .divisor  (SUM_W'(n_lat_q)),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DRAIN) || (state_q == ST_DIVIDE);
   assign done      = (state_q == ST_DONE);
   assign err_cnt   = err_cnt_q;
   assign max_ed    = max_q;
   assign sum_ed    = sum_q;
   assign sum_sat   = sat_q;
   assign mean_ed   = mean_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_err_metric_monitor.sv
`timescale 1ns/1ps
module tb_err_metric_monitor;
   import approx_metric_pkg::*;

   localparam int W      = 32;
   localparam int CNT_W  = 32;
   localparam int SUM_W  = 64;
   localparam int SUM_WS = 33;

   typedef struct packed {
      logic [31:0] err;
      logic [31:0] mx;
      logic [63:0] sum;
      logic        sat;
      logic [63:0] mean;
   } exp_t;

   // ---------------- clock / reset / signals ----------------
   logic clk = 1'b0;
   logic rst, start, start_s, in_valid;
   logic [CNT_W-1:0] n_samples;
   logic [W-1:0] exact, approx;

   logic in_ready, busy, done, sum_sat;
   logic [CNT_W-1:0] err_cnt;
   logic [W-1:0] max_ed;
   logic [SUM_W-1:0] sum_ed, mean_ed;
   metric_state_e dbg_state;

   logic in_ready_s, busy_s, done_s, sum_sat_s;
   logic [CNT_W-1:0] err_cnt_s;
   logic [W-1:0] max_ed_s;
   logic [SUM_WS-1:0] sum_ed_s, mean_ed_s;
   metric_state_e dbg_state_s;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   err_metric_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
      .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready), .exact(exact), .approx(approx),
      .busy(busy), .done(done), .err_cnt(err_cnt), .max_ed(max_ed),
      .sum_ed(sum_ed), .sum_sat(sum_sat), .mean_ed(mean_ed), .dbg_state(dbg_state)
   );

   // Narrow-accumulator instance, started only for the saturation window.
   err_metric_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_WS)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready_s), .exact(exact), .approx(approx),
      .busy(busy_s), .done(done_s), .err_cnt(err_cnt_s), .max_ed(max_ed_s),
      .sum_ed(sum_ed_s), .sum_sat(sum_sat_s), .mean_ed(mean_ed_s), .dbg_state(dbg_state_s)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   int   exp_cyc_q[$];
   exp_t exp_s_q[$];
   int   exp_s_cyc_q[$];
   logic [W-1:0] stim_e[$];
   logic [W-1:0] stim_a[$];
   bit           vpat[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, req);
      end
   endtask

   // Reference: plain arithmetic over the first n pairs, wide enough never to wrap.
   function automatic exp_t model(input int n, input int sumw);
      exp_t e;
      logic [127:0] full, lim, d, clamped;
      e = '0;
      full = '0;
      lim = (128'd1 << sumw) - 128'd1;
      for (int i = 0; i < n; i++) begin
         if (stim_e[i] > stim_a[i]) d = 128'(stim_e[i]) - 128'(stim_a[i]);
         else                       d = 128'(stim_a[i]) - 128'(stim_e[i]);
         if (stim_e[i] != stim_a[i]) e.err = e.err + 32'd1;
         if (d > 128'(e.mx)) e.mx = d[31:0];
         full = full + d;
      end
      e.sat = (full > lim);
      clamped = e.sat ? lim : full;
      e.sum = clamped[63:0];
      e.mean = (n == 0) ? 64'd0 : 64'(clamped / 128'(n));
      return e;
   endfunction

   // ---------------- monitors ----------------
   logic done_d = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      int dc;
      if (!rst && done && !done_d) begin
         if (exp_q.size() == 0 || exp_cyc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
         end else begin
            e  = exp_q.pop_front();
            dc = exp_cyc_q.pop_front();
            chk("err_cnt", err_cnt, e.err);
            chk("max_ed", max_ed, e.mx);
            chk("sum_ed", sum_ed, e.sum);
            chk("sum_sat", sum_sat, e.sat);
            chk("mean_ed", mean_ed, e.mean);
            chk("done_cycle", cyc, dc);
            chk("busy_in_done", busy, 0);
         end
      end
      done_d <= done;
   end

   logic done_s_d = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      int dc;
      if (!rst && done_s && !done_s_d && exp_s_q.size() != 0 && exp_s_cyc_q.size() != 0) begin
         e  = exp_s_q.pop_front();
         dc = exp_s_cyc_q.pop_front();
         chk("s_err_cnt", err_cnt_s, e.err);
         chk("s_max_ed", max_ed_s, e.mx);
         chk("s_sum_ed", sum_ed_s, e.sum[SUM_WS-1:0]);
         chk("s_sum_sat", sum_sat_s, e.sat);
         chk("s_mean_ed", mean_ed_s, e.mean[SUM_WS-1:0]);
         chk("s_done_cycle", cyc, dc);
      end
      done_s_d <= done_s;
   end

   // ---------------- driver tasks ----------------
   task automatic check_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err_cnt"}, err_cnt, 0);
      chk({tag, "_max_ed"}, max_ed, 0);
      chk({tag, "_sum_ed"}, sum_ed, 0);
      chk({tag, "_sum_sat"}, sum_sat, 0);
      chk({tag, "_mean_ed"}, mean_ed, 0);
      chk({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   // Called at #1 after a rising edge. Issues start, then feeds stim_e/stim_a
   // (valid pattern from vpat first, then always-on or random bubbles).
   task automatic run_window(input int n, input bit rnd, input bit push, input bit both);
      int xfers, vi, t, s;
      bit v;
      n_samples = n;
      start     = 1'b1;
      start_s   = both;
      in_valid  = 1'b0;
      s = cyc;
      if (push) begin
         exp_q.push_back(model(n, SUM_W));
         if (n == 0) exp_cyc_q.push_back(s + 1);
      end
      if (both) exp_s_q.push_back(model(n, SUM_WS));
      @(posedge clk); #1;
      start = 1'b0;
      start_s = 1'b0;
      xfers = 0; vi = 0; t = 0;
      while ((xfers < n || vi < vpat.size()) && t < 20000) begin
         if (vi < vpat.size()) begin
            v = vpat[vi];
            vi++;
         end else begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         in_valid = v;
         if (xfers < n) begin
            exact  = stim_e[xfers];
            approx = stim_a[xfers];
         end else begin
            exact  = $urandom;
            approx = $urandom;
         end
         if (rnd && $urandom_range(0, 30) == 0) begin
            start = 1'b1;
            n_samples = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (in_valid && xfers >= n) chk("in_ready_after_n", in_ready, 0);
         if (in_valid && in_ready) begin
            xfers++;
            if (xfers == n) begin
               if (push) exp_cyc_q.push_back(cyc + SUM_W + 2);
               if (both) exp_s_cyc_q.push_back(cyc + SUM_WS + 2);
            end
         end
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      chk("transfer_count", xfers, n);
      vpat.delete();
   endtask

   // Waits for done; optionally pulses start while the window is still busy.
   task automatic wait_done(input bit pulses);
      int t;
      t = 0;
      while (!done && t < 5000) begin
         start = pulses && ($urandom_range(0, 7) == 0);
         n_samples = $urandom;
         @(posedge clk); #1;
         start = 1'b0;
         t++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_done actual=0 expected=1 cyc=%0d", cyc);
      end
   endtask

   task automatic add_pair(input logic [W-1:0] e, input logic [W-1:0] a);
      stim_e.push_back(e);
      stim_a.push_back(a);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] ma, mb;
      int n;
      rst = 1'b1; start = 1'b1; start_s = 1'b1; in_valid = 1'b1;
      n_samples = 5; exact = 1; approx = 2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; start_s = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;

      // Empty window: DONE immediately, in_ready stays low.
      stim_e.delete(); stim_a.delete();
      vpat = '{1, 1, 1};
      run_window(0, 0, 1, 0);
      wait_done(0);

      // Basic four-pair window.
      stim_e.delete(); stim_a.delete();
      add_pair(10, 10); add_pair(10, 7); add_pair(3, 8); add_pair(100, 100);
      run_window(4, 0, 1, 0);
      wait_done(0);

      // Bubbles plus extra valids after the window fills.
      stim_e.delete(); stim_a.delete();
      add_pair(1, 2); add_pair(5, 5); add_pair(9, 1);
      vpat = '{1, 0, 0, 1, 1, 1, 1};
      run_window(3, 0, 1, 0);
      wait_done(0);

      // Saturation on the 33-bit accumulator instance.
      stim_e.delete(); stim_a.delete();
      for (int i = 0; i < 3; i++) add_pair(32'hFFFF_FFFF, 32'h0);
      run_window(3, 0, 1, 1);
      wait_done(0);

      // Reset in the middle of the divide, then a fresh window.
      stim_e.delete(); stim_a.delete();
      add_pair(20, 3); add_pair(7, 9);
      run_window(2, 0, 0, 0);
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_zero("mid_div_rst");
      @(posedge clk); #1;
      stim_e.delete(); stim_a.delete();
      add_pair(6, 2);
      run_window(1, 0, 1, 0);
      wait_done(0);

      // Short random windows with arbitrary 32-bit pairs.
      for (int k = 0; k < 3; k++) begin
         stim_e.delete(); stim_a.delete();
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               exact = $urandom;
               add_pair(exact, exact);
            end else begin
               add_pair($urandom, $urandom);
            end
         end
         run_window(n, 1, 1, 0);
         wait_done(1);
      end

      // Long window against a 16x16 approximate multiplier, busy starts injected.
      stim_e.delete(); stim_a.delete();
      n = 1500;
      for (int i = 0; i < n; i++) begin
         ma = 16'($urandom);
         mb = 16'($urandom);
         if (ma[0]) add_pair(32'(ma) * 32'(mb), 32'(ma) * 32'(mb & 16'hFFFC));
         else       add_pair(32'(ma) * 32'(mb), 32'(ma | 16'h1) * 32'(mb));
      end
      run_window(n, 1, 1, 0);
      wait_done(1);

      repeat (3) @(posedge clk);
      chk("exp_q_left", exp_q.size(), 0);
      chk("exp_s_q_left", exp_s_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
